// File: rtl/fir_coef_bank.sv
// fir_coef_bank: double-buffered FIR coefficient store.
// The filter reads the active bank while the host streams a new set into the
// shadow bank; a requested swap is applied only on a filter frame boundary.
module fir_coef_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
    input  logic              swap_req,
    input  logic              frame_sync,
    output logic              swap_pending,
    output logic              active_bank,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, LOAD, FULL, PEND} state_t;

    // Last shadow address, and the bank depth widened by one bit so that an
    // address range check works even when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_d;
    logic [ADDR_W-1:0] wcnt, wcnt_d;
    logic              wr_en;
    logic              done_d;
    logic              toggle;
    logic              start_ok;
    logic              err_set;

    // Both banks; the shadow bank is always the one not being read.
    logic [DATA_W-1:0] mem [2][DEPTH];

    assign ld_ready = (state == LOAD);

    // Next-state, write strobe, swap and error decode.
    // NOTE: every signal gets a default before the case so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d  = state;
        wcnt_d   = wcnt;
        wr_en    = 1'b0;
        done_d   = 1'b0;
        toggle   = 1'b0;
        start_ok = 1'b0;
        err_set  = ld_valid && !ld_ready;
        case (state)
            IDLE: begin
                if (swap_req) err_set = 1'b1;
                if (ld_start) begin
                    state_d  = LOAD;
                    wcnt_d   = '0;
                    start_ok = 1'b1;
                end
            end
            LOAD: begin
                if (swap_req) err_set = 1'b1;
                if (ld_start) begin
                    // Restart wins over a word offered in the same cycle.
                    wcnt_d   = '0;
                    start_ok = 1'b1;
                end else if (ld_valid) begin
                    wr_en = 1'b1;
                    if (wcnt == LAST_ADDR) begin
                        state_d = FULL;
                        wcnt_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        wcnt_d = wcnt + 1'b1;
                    end
                end
            end
            FULL: begin
                if (ld_start) begin
                    state_d  = LOAD;
                    wcnt_d   = '0;
                    start_ok = 1'b1;
                end else if (swap_req) begin
                    if (frame_sync) begin
                        toggle  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (ld_start) err_set = 1'b1;
                if (frame_sync) begin
                    toggle  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wcnt         <= '0;
            active_bank  <= 1'b0;
            ld_done      <= 1'b0;
            swap_pending <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_d;
            wcnt         <= wcnt_d;
            ld_done      <= done_d;
            swap_pending <= (state_d == PEND);
            if (toggle) active_bank <= ~active_bank;
            if (err_set)       err <= 1'b1;
            else if (start_ok) err <= 1'b0;
        end
    end

    // Shadow-bank write port.
    // NOTE: the coefficient array is deliberately not reset; contents are
    // only meaningful after a load, and a reset would bloat the register file.
    always_ff @(posedge clk) begin
        if (wr_en) mem[~active_bank][wcnt] <= ld_data;
    end

    // Registered read of the active bank; out-of-range taps read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if ({1'b0, rd_addr} < DEPTH_LIM) rd_data <= mem[active_bank][rd_addr];
            else                             rd_data <= '0;
        end
    end

endmodule
